// File: rtl/music_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : music_ctrl_pkg
//  Brief   : Shared state encodings, default sizing and song-index helper for
//            the music playback controller and its neighbours.
//  Macro   : MUSIC_CTRL_AUTOADV_EN (enables the GAP state in music_ctrl)
//  Rev     : 1.0  initial release
// ============================================================================
package music_ctrl_pkg;

  // Controller run states; ST_GAP is only reachable with auto-advance built in
  typedef enum logic [1:0] {
    ST_RST     = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_PLAYING = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_SONGS  = 4;
  localparam int unsigned DEF_SONG_W     = 2;
  localparam int unsigned DEF_GAP_CYCLES = 16;

  // Next song index, wrapping the last song back to song 0
  function automatic int unsigned next_song_idx(input int unsigned cur,
                                                input int unsigned num);
    return (cur + 1 >= num) ? 0 : cur + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/music_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : music_ctrl_if
//  Brief   : Button / song_reader bundle around the playback controller.
//            master = controller side, slave = buttons + song_reader side.
//  Macro   : MUSIC_CTRL_AUTOADV_EN (gap_active is constant 0 without it)
//  Rev     : 1.0  initial release
// ============================================================================
interface music_ctrl_if #(
  parameter int unsigned SONG_W = 2
);
  logic              play_button;
  logic              next_button;
  logic              song_done;
  logic              play;
  logic [SONG_W-1:0] song;
  logic              player_reset;
  logic              gap_active;

  modport master (
    input  play_button, next_button, song_done,
    output play, song, player_reset, gap_active
  );

  modport slave (
    output play_button, next_button, song_done,
    input  play, song, player_reset, gap_active
  );
endinterface
`default_nettype wire

// File: rtl/music_ctrl_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module  : music_ctrl_gap_timer
//  Brief   : Inter-song gap counter. Counts 0..GAP_CYCLES-1 while enabled and
//            flags the terminal count; clear has priority and zeroes it.
//  Macro   : used by music_ctrl only when MUSIC_CTRL_AUTOADV_EN is defined
//  Rev     : 1.0  initial release
// ============================================================================
module music_ctrl_gap_timer #(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_clear,
  input  wire  i_en,
  output logic o_tc
);
  localparam int unsigned W = $clog2(GAP_CYCLES + 1);
  localparam logic [W-1:0] C_TERM = W'(GAP_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Terminal count is combinational so the controller leaves GAP on that edge
  assign o_tc = i_en && !i_clear && (r_cnt == C_TERM);

  // Gap counter: clear on reset/abort, wrap to 0 on terminal count
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/music_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : music_ctrl
//  Brief   : Playback controller for song_reader. Turns play/pause and next
//            button pulses plus song_done into play, song index and a
//            one-cycle player_reset rewind pulse. All outputs registered.
//  Macro   : MUSIC_CTRL_AUTOADV_EN - song_done advances to the next song
//            after a GAP_CYCLES silent gap; otherwise it rewinds and pauses.
//  Rev     : 1.0  initial release
// ============================================================================
module music_ctrl
  import music_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SONGS  = DEF_NUM_SONGS,
  parameter int unsigned SONG_W     = DEF_SONG_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  wire          clk,
  input  wire          reset,
  music_ctrl_if.master bus
);

  // Elaboration-time sanity checks on the configuration
  if ((2 ** SONG_W) < NUM_SONGS) begin : g_bad_song_w
    $error("music_ctrl: SONG_W too narrow for NUM_SONGS");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("music_ctrl: GAP_CYCLES must be >= 1");
  end

  state_t            r_state;
  logic              r_resume;
  logic [SONG_W-1:0] r_song;
  logic              r_play;
  logic              r_player_reset;
  logic [SONG_W-1:0] w_song_next;
  logic              w_gap_tc;

  assign w_song_next = SONG_W'(next_song_idx(32'(r_song), NUM_SONGS));

`ifdef MUSIC_CTRL_AUTOADV_EN
  logic r_gap_active;
  logic w_gap_en;
  logic w_gap_clear;

  // Timer runs only inside GAP; any exit or button abort zeroes it
  assign w_gap_en    = (r_state == ST_GAP);
  assign w_gap_clear = !w_gap_en || bus.next_button || bus.play_button;

  music_ctrl_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_gap_clear),
    .i_en    (w_gap_en),
    .o_tc    (w_gap_tc)
  );

  assign bus.gap_active = r_gap_active;
`else
  assign w_gap_tc       = 1'b0;
  assign bus.gap_active = 1'b0;
`endif

  // Controller FSM with registered outputs; player_reset is high only in RST
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_RST;
      r_resume       <= 1'b0;
      r_song         <= '0;
      r_play         <= 1'b0;
      r_player_reset <= 1'b1;
`ifdef MUSIC_CTRL_AUTOADV_EN
      r_gap_active   <= 1'b0;
`endif
    end else begin
      r_player_reset <= 1'b0;
      case (r_state)
        // One-cycle rewind; buttons ignored here
        ST_RST: begin
          r_state <= r_resume ? ST_PLAYING : ST_PAUSED;
          r_play  <= r_resume;
        end

        ST_PAUSED: begin
          if (bus.next_button) begin
            r_song         <= w_song_next;
            r_resume       <= 1'b0;
            r_state        <= ST_RST;
            r_player_reset <= 1'b1;
          end else if (bus.play_button) begin
            r_state <= ST_PLAYING;
            r_play  <= 1'b1;
          end
        end

        ST_PLAYING: begin
          if (bus.next_button) begin
            r_song         <= w_song_next;
            r_resume       <= 1'b0;
            r_state        <= ST_RST;
            r_play         <= 1'b0;
            r_player_reset <= 1'b1;
          end else if (bus.song_done) begin
`ifdef MUSIC_CTRL_AUTOADV_EN
            r_state      <= ST_GAP;
            r_play       <= 1'b0;
            r_gap_active <= 1'b1;
`else
            r_resume       <= 1'b0;
            r_state        <= ST_RST;
            r_play         <= 1'b0;
            r_player_reset <= 1'b1;
`endif
          end else if (bus.play_button) begin
            r_state <= ST_PAUSED;
            r_play  <= 1'b0;
          end
        end

`ifdef MUSIC_CTRL_AUTOADV_EN
        // Silent gap: a button aborts to paused, terminal count resumes play
        ST_GAP: begin
          if (bus.next_button || bus.play_button) begin
            r_song         <= w_song_next;
            r_resume       <= 1'b0;
            r_state        <= ST_RST;
            r_gap_active   <= 1'b0;
            r_player_reset <= 1'b1;
          end else if (w_gap_tc) begin
            r_song         <= w_song_next;
            r_resume       <= 1'b1;
            r_state        <= ST_RST;
            r_gap_active   <= 1'b0;
            r_player_reset <= 1'b1;
          end
        end
`endif

        default: begin
          r_state        <= ST_RST;
          r_resume       <= 1'b0;
          r_play         <= 1'b0;
          r_player_reset <= 1'b1;
        end
      endcase
    end
  end

  assign bus.play         = r_play;
  assign bus.song         = r_song;
  assign bus.player_reset = r_player_reset;

  // Gap timer output is only consumed with auto-advance built in
  logic w_unused;
  assign w_unused = w_gap_tc;

endmodule
`default_nettype wire
